// File: rtl/axi3_to_ahb_bridge.sv
// AXI3 slave to AHB-Lite master bridge: one AXI burst at a time, each beat replayed
// as an AHB SINGLE NONSEQ transfer, read data / write response returned on AXI.
module axi3_to_ahb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [DATA_WIDTH-1:0] hrdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_DATA   = 3'd1,
    AHB_ADDR = 3'd2,
    AHB_DATA = 3'd3,
    R_RESP   = 3'd4,
    B_RESP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  rd_pri_q, rd_pri_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  write_q, write_d;
  logic [3:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;

  logic                  grant_rd, grant_wr, last_beat;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  unused_w;

  // WRAP keeps the low bits inside a (len+1)<<size byte block; FIXED holds the address
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [3:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    incr = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + incr) & mask);
      default: next_addr = a + incr;
    endcase
  endfunction

  assign unused_w  = ^{wstrb, wlast};
  assign grant_rd  = arvalid & (~awvalid | rd_pri_q);
  assign grant_wr  = awvalid & ~grant_rd;
  assign last_beat = (beat_q == len_q);
  assign addr_nxt  = next_addr(addr_q, len_q, size_q, burst_q);

  always_comb begin
    state_d  = state_q;
    rd_pri_d = rd_pri_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    write_d  = write_q;
    beat_d   = beat_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    arready  = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    rvalid   = 1'b0;
    bvalid   = 1'b0;
    htrans   = 2'b00;
    case (state_q)
      IDLE: begin
        arready = grant_rd;
        awready = grant_wr;
        // Priority only flips when both channels contended in the same cycle
        if (grant_rd) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = arburst;
          write_d = 1'b0;
          beat_d  = 4'd0;
          err_d   = 1'b0;
          state_d = AHB_ADDR;
          if (awvalid) rd_pri_d = 1'b0;
        end else if (grant_wr) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = awburst;
          write_d = 1'b1;
          beat_d  = 4'd0;
          err_d   = 1'b0;
          state_d = W_DATA;
          if (arvalid) rd_pri_d = 1'b1;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          wdata_d = wdata;
          state_d = AHB_ADDR;
        end
      end
      AHB_ADDR: begin
        htrans = 2'b10;
        if (hready) state_d = AHB_DATA;
      end
      AHB_DATA: begin
        if (hready) begin
          if (!write_q) begin
            rdata_d = hrdata;
            rerr_d  = hresp;
            state_d = R_RESP;
          end else begin
            err_d = err_q | hresp;
            if (last_beat) begin
              state_d = B_RESP;
            end else begin
              beat_d  = beat_q + 4'd1;
              addr_d  = addr_nxt;
              state_d = W_DATA;
            end
          end
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 4'd1;
            addr_d  = addr_nxt;
            state_d = AHB_ADDR;
          end
        end
      end
      B_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_pri_q <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      write_q  <= 1'b0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_pri_q <= rd_pri_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      write_q  <= write_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  // AHB address-phase signals come straight from the latched burst state so they hold during waits
  assign haddr  = addr_q;
  assign hwrite = write_q;
  assign hsize  = (size_q > 3'd2) ? 3'd2 : size_q;
  assign hburst = 3'b000;
  assign hwdata = wdata_q;
  assign rdata  = rdata_q;
  assign rresp  = {rerr_q, 1'b0};
  assign rlast  = (state_q == R_RESP) && last_beat;
  assign rid    = id_q;
  assign bid    = id_q;
  assign bresp  = {err_q, 1'b0};

endmodule

// File: tb/tb_axi3_to_ahb_bridge.sv
// Randomized bench for axi3_to_ahb_bridge: drives AXI bursts and an AHB slave,
// and compares every AHB transfer and AXI response with a burst-level model.
module tb_axi3_to_ahb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata, haddr, hwdata, hrdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize, hsize, hburst;
  logic [1:0]  awburst, arburst, bresp, rresp, htrans;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, hwrite, hready, hresp;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc_cnt = 0;

  axi3_to_ahb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Address of beat i computed directly from the burst rules
  function automatic logic [31:0] model_addr(input logic [31:0] start, input int i,
                                             input int len, input int size, input int burst);
    longint unsigned bytes, blk, base, s;
    bytes = longint'(1) << size;
    s = longint'(start);
    case (burst)
      0: return start;
      2: begin
        blk  = longint'(len + 1) * bytes;
        base = (s / blk) * blk;
        return 32'(base + ((s - base) + longint'(i) * bytes) % blk);
      end
      default: return 32'(s + longint'(i) * bytes);
    endcase
  endfunction

  function automatic logic [2:0] model_hsize(input int size);
    return (size > 2) ? 3'd2 : 3'(size);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {arready, awready, wready, rvalid, bvalid, htrans, hwrite, hsize, hburst,
                        rresp, rlast, rid, bid, bresp}, 64'd0);
    chk({tag, "_haddr"}, haddr, 64'd0);
    chk({tag, "_hwdata"}, hwdata, 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input logic [15:0] emask,
                         input bit rnd, input int sbeat, input int sn, input bit chk_lat,
                         input int rst_beat);
    int n, h, wa, wd, st;
    logic [31:0] d, ea;
    arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 20) begin cyc(); #1; n++; end
    if (!arready) begin chk("rd_ar_timeout", 0, 1); arvalid = 1'b0; return; end
    cyc();
    arvalid = 1'b0;
    h = int'(cyc_cnt);
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (htrans !== 2'b10 && n < 20) begin cyc(); n++; end
      if (htrans !== 2'b10) begin chk("rd_addr_timeout", 0, 1); return; end
      if (chk_lat && i == 0) chk("rd_addr_lat", int'(cyc_cnt) - h + 1, 1);
      ea = model_addr(addr, i, len, size, burst);
      chk("rd_haddr", haddr, ea);
      chk("rd_hwrite", hwrite, 0);
      chk("rd_hsize", hsize, model_hsize(size));
      chk("rd_hburst", hburst, 0);
      chk("rd_busy", {arready, awready}, 0);
      wa = rnd ? int'($urandom_range(0, 2)) : ((i == sbeat) ? sn : 0);
      wd = rnd ? int'($urandom_range(0, 2)) : ((i == sbeat) ? sn : 0);
      for (int w = 0; w < wa; w++) begin
        hready = 1'b0; cyc();
        chk("rd_addr_hold", {htrans, haddr}, {2'b10, ea});
      end
      hready = 1'b1; cyc();
      if (i == rst_beat) begin
        hready = 1'b0; #1;
        rst = 1'b1; #1;
        chk_reset_vals("rst_mid");
        cyc();
        rst = 1'b0; hready = 1'b1;
        return;
      end
      d = $urandom;
      for (int w = 0; w < wd; w++) begin
        hready = 1'b0; hrdata = $urandom; hresp = 1'($urandom_range(0, 1)); cyc();
        chk("rd_data_htrans", htrans, 0);
      end
      hready = 1'b1; hrdata = d; hresp = emask[i]; cyc();
      hresp = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin cyc(); n++; end
      if (!rvalid) begin chk("rd_rvalid_timeout", 0, 1); return; end
      if (chk_lat && i == 0) chk("rd_rvalid_lat", int'(cyc_cnt) - h + 1, 3);
      chk("rd_rdata", rdata, d);
      chk("rd_rresp", rresp, emask[i] ? 2'b10 : 2'b00);
      chk("rd_rlast", rlast, (i == len));
      chk("rd_rid", rid, id);
      st = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int w = 0; w < st; w++) begin
        rready = 1'b0; cyc();
        chk("rd_rvalid_hold", rvalid, 1);
      end
      rready = 1'b1; cyc();
      rready = 1'b0;
    end
    chk("rd_done", rvalid, 0);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input logic [15:0] emask,
                          input bit rnd, input int sbeat, input int sn, input bit chk_lat);
    int n, h, wa, wd, st;
    logic [31:0] d, ea;
    bit anyerr;
    anyerr = 1'b0;
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 20) begin cyc(); #1; n++; end
    if (!awready) begin chk("wr_aw_timeout", 0, 1); awvalid = 1'b0; return; end
    cyc();
    awvalid = 1'b0;
    h = int'(cyc_cnt);
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!wready && n < 20) begin cyc(); n++; end
      if (!wready) begin chk("wr_wready_timeout", 0, 1); return; end
      if (chk_lat && i == 0) chk("wr_wready_lat", int'(cyc_cnt) - h + 1, 1);
      st = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int w = 0; w < st; w++) cyc();
      d = $urandom;
      wvalid = 1'b1; wdata = d; wstrb = 4'($urandom); wlast = 1'($urandom_range(0, 1));
      cyc();
      wvalid = 1'b0; wdata = $urandom;
      n = 0;
      while (htrans !== 2'b10 && n < 20) begin cyc(); n++; end
      if (htrans !== 2'b10) begin chk("wr_addr_timeout", 0, 1); return; end
      if (chk_lat && i == 0) chk("wr_addr_lat", int'(cyc_cnt) - h + 1, 2);
      ea = model_addr(addr, i, len, size, burst);
      chk("wr_haddr", haddr, ea);
      chk("wr_hwrite", hwrite, 1);
      chk("wr_hsize", hsize, model_hsize(size));
      chk("wr_busy", {arready, awready}, 0);
      wa = rnd ? int'($urandom_range(0, 2)) : ((i == sbeat) ? sn : 0);
      wd = rnd ? int'($urandom_range(0, 2)) : ((i == sbeat) ? sn : 0);
      for (int w = 0; w < wa; w++) begin
        hready = 1'b0; cyc();
        chk("wr_addr_hold", {htrans, haddr}, {2'b10, ea});
      end
      hready = 1'b1; cyc();
      chk("wr_hwdata", hwdata, d);
      for (int w = 0; w < wd; w++) begin
        hready = 1'b0; hresp = emask[i] ? 1'b1 : 1'($urandom_range(0, 1)); cyc();
        chk("wr_data_hold", {htrans, hwdata}, {2'b00, d});
      end
      hready = 1'b1; hresp = emask[i]; cyc();
      hresp = 1'b0;
      anyerr |= emask[i];
    end
    n = 0;
    while (!bvalid && n < 20) begin cyc(); n++; end
    if (!bvalid) begin chk("wr_bvalid_timeout", 0, 1); return; end
    if (chk_lat && len == 0) chk("wr_bvalid_lat", int'(cyc_cnt) - h + 1, 4);
    chk("wr_bresp", bresp, anyerr ? 2'b10 : 2'b00);
    chk("wr_bid", bid, id);
    st = rnd ? int'($urandom_range(0, 2)) : 0;
    for (int w = 0; w < st; w++) begin
      bready = 1'b0; cyc();
      chk("wr_bvalid_hold", bvalid, 1);
    end
    bready = 1'b1; cyc();
    bready = 1'b0;
    chk("wr_done", bvalid, 0);
  endtask

  initial begin
    int len, size, burst;
    logic [31:0] a;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (3) cyc();
    chk_reset_vals("reset");
    rst = 1'b0;
    cyc();

    // First contended pair: read wins, the held write follows
    awid = 4'h2; awaddr = 32'h200; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'h1; araddr = 32'h100; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("arb1_ar", arready, 1);
    chk("arb1_aw", awready, 0);
    do_read(4'h1, 32'h100, 0, 2, 1, 16'h0, 1'b0, -1, 0, 1'b1, -1);
    do_write(4'h2, 32'h200, 3, 2, 1, 16'h0, 1'b0, -1, 0, 1'b1);

    // Second contended pair: write wins
    awid = 4'h3; awaddr = 32'h300; awlen = 4'd1; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'h4; araddr = 32'h38; arlen = 4'd3; arsize = 3'd2; arburst = 2'b10; arvalid = 1'b1;
    #1;
    chk("arb2_aw", awready, 1);
    chk("arb2_ar", arready, 0);
    do_write(4'h3, 32'h300, 1, 2, 1, 16'h1, 1'b0, 1, 2, 1'b0);
    do_read(4'h4, 32'h38, 3, 2, 2, 16'h4, 1'b0, 2, 1, 1'b0, -1);

    do_read(4'h5, 32'h400, 1, 3, 1, 16'h0, 1'b0, -1, 0, 1'b0, -1);
    do_write(4'h6, 32'h500, 0, 2, 1, 16'h0, 1'b0, -1, 0, 1'b1);
    do_read(4'h7, 32'h600, 2, 1, 0, 16'h2, 1'b0, -1, 0, 1'b0, -1);
    do_write(4'h8, 32'h700, 2, 0, 3, 16'h0, 1'b0, -1, 0, 1'b0);

    do_read(4'h9, 32'h800, 3, 2, 1, 16'h0, 1'b0, -1, 0, 1'b0, 2);
    do_read(4'hA, 32'h900, 0, 2, 1, 16'h0, 1'b0, -1, 0, 1'b1, -1);

    for (int t = 0; t < 40; t++) begin
      size  = int'($urandom_range(0, 2));
      burst = int'($urandom_range(0, 3));
      len   = (burst == 2) ? ((2 << $urandom_range(0, 3)) - 1) : int'($urandom_range(0, 15));
      a     = $urandom_range(0, 32'hFFFF) & ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 1) == 1)
        do_read(4'($urandom), a, len, size, burst, 16'($urandom & $urandom & $urandom),
                1'b1, -1, 0, 1'b0, -1);
      else
        do_write(4'($urandom), a, len, size, burst, 16'($urandom & $urandom & $urandom),
                 1'b1, -1, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
